// File: rtl/fp_normalize_round.sv
// Normalise / round / pack back end of the binary32 adder.
// Normalisation walks one bit per cycle; rounding is nearest-even.
module fp_normalize_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic [FRAC_W+3:0]       mant_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    overflow
);

    localparam int MW = FRAC_W + 4;
    localparam int IW = EXP_W + 2;
    localparam logic [IW-1:0] EXP_ONE = IW'(1);
    localparam logic [IW-1:0] EXP_MAX = IW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic                   r_sign;
    logic                   r_zero;
    logic [IW-1:0]          r_exp;
    logic [MW-1:0]          r_mant;
    logic [EXP_W+FRAC_W:0]  r_result;
    logic                   r_overflow;

    logic                   w_shiftDone;
    logic                   w_inc;
    logic [FRAC_W+1:0]      w_sum;
    logic                   w_carry;
    logic                   w_hidden;
    logic [FRAC_W-1:0]      w_frac;
    logic [IW-1:0]          w_expRnd;
    logic                   w_ovf;
    logic [EXP_W-1:0]       w_expField;
    logic [EXP_W+FRAC_W:0]  w_roundResult;

    // Normalisation stops on zero, a carry, a set hidden bit, or the subnormal floor.
    assign w_shiftDone = (r_mant == '0) || r_mant[MW-1] || r_mant[MW-2] || (r_exp == EXP_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_nextState = SHIFT;
            SHIFT:   if (w_shiftDone) w_nextState = ROUND;
            ROUND:                    w_nextState = DONE;
            DONE:    if (out_ready)   w_nextState = IDLE;
            default:                  w_nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    // Round at bit 2 using guard (bit 1) and sticky (bit 0); a carry out renormalises.
    always_comb begin
        w_inc      = r_mant[1] & (r_mant[0] | r_mant[2]);
        w_sum      = {1'b0, r_mant[MW-2:2]} + {{(FRAC_W+1){1'b0}}, w_inc};
        w_carry    = w_sum[FRAC_W+1];
        w_hidden   = w_carry | w_sum[FRAC_W];
        w_frac     = w_carry ? w_sum[FRAC_W:1] : w_sum[FRAC_W-1:0];
        w_expRnd   = r_exp + {{(IW-1){1'b0}}, w_carry};
        w_ovf      = !r_zero && (w_expRnd >= EXP_MAX);
        w_expField = w_hidden ? w_expRnd[EXP_W-1:0] : '0;
        if (r_zero) begin
            w_roundResult = '0;
        end else if (w_ovf) begin
            w_roundResult = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            w_roundResult = {r_sign, w_expField, w_frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign     <= 1'b0;
            r_zero     <= 1'b0;
            r_exp      <= '0;
            r_mant     <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= sign_in;
                        r_zero <= 1'b0;
                        r_exp  <= (exp_in == '0) ? EXP_ONE : IW'(exp_in);
                        r_mant <= mant_in;
                    end
                end
                SHIFT: begin
                    if (r_mant == '0) begin
                        r_zero <= 1'b1;
                    end else if (r_mant[MW-1]) begin
                        r_mant <= {1'b0, r_mant[MW-1:2], r_mant[1] | r_mant[0]};
                        r_exp  <= r_exp + EXP_ONE;
                    end else if (!(r_mant[MW-2] || (r_exp == EXP_ONE))) begin
                        r_mant <= {r_mant[MW-2:0], 1'b0};
                        r_exp  <= r_exp - EXP_ONE;
                    end
                end
                ROUND: begin
                    r_result   <= w_roundResult;
                    r_overflow <= w_ovf;
                end
                default: begin
                end
            endcase
        end
    end

    assign result   = r_result;
    assign overflow = r_overflow;

endmodule
